// File: rtl/jtag_dtm.sv
// RISC-V JTAG Debug Transport Module. The JTAG pins are oversampled in the clk
// domain; DMI scans become valid/ready requests towards the debug module.
module jtag_dtm #(
    parameter logic [31:0] IDCODE      = 32'h1000_0001,
    parameter int          SYNC_STAGES = 2,
    parameter logic [2:0]  IDLE_HINT   = 3'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        tdo_en,
    output logic        dmi_valid,
    input  logic        dmi_ready,
    output logic        dmi_write,
    output logic [6:0]  dmi_addr,
    output logic [31:0] dmi_wdata,
    input  logic [31:0] dmi_rdata
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    localparam logic [1:0] SEL_BYPASS = 2'd0;
    localparam logic [1:0] SEL_ID     = 2'd1;
    localparam logic [1:0] SEL_CS     = 2'd2;
    localparam logic [1:0] SEL_DMI    = 2'd3;

    // ---------------------------------------------------------------------
    // Pin synchronisers and tck edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
    logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
    logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
    logic                   tck_prev_q, tck_prev_d;
    logic                   tck_s, tms_s, tdi_s;
    logic                   tck_rise, tck_fall;

    always_comb begin
        tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], tck};
        tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], tms};
        tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], tdi};
        tck_s      = tck_sync_q[SYNC_STAGES-1];
        tms_s      = tms_sync_q[SYNC_STAGES-1];
        tdi_s      = tdi_sync_q[SYNC_STAGES-1];
        tck_prev_d = tck_s;
        tck_rise   = tck_s & ~tck_prev_q;
        tck_fall   = ~tck_s & tck_prev_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= tck_sync_d;
            tms_sync_q <= tms_sync_d;
            tdi_sync_q <= tdi_sync_d;
            tck_prev_q <= tck_prev_d;
        end
    end

    // ---------------------------------------------------------------------
    // TAP controller
    // ---------------------------------------------------------------------
    tap_state_e tap_state_q, tap_state_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tap_state_q <= TLR;
        end else begin
            tap_state_q <= tap_state_d;
        end
    end

    always_comb begin
        tap_state_d = tap_state_q;
        if (tck_rise) begin
            unique case (tap_state_q)
                TLR:     tap_state_d = tms_s ? TLR    : RTI;
                RTI:     tap_state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:  tap_state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:  tap_state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:   tap_state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:  tap_state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR:  tap_state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR:  tap_state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:  tap_state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:  tap_state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:  tap_state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:   tap_state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:  tap_state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR:  tap_state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR:  tap_state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:  tap_state_d = tms_s ? SEL_DR : RTI;
                default: tap_state_d = TLR;
            endcase
        end
    end

    logic in_tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, ir_side;

    always_comb begin
        in_tlr  = (tap_state_q == TLR);
        cap_ir  = (tap_state_q == CAP_IR);
        sh_ir   = (tap_state_q == SH_IR);
        upd_ir  = (tap_state_q == UPD_IR);
        cap_dr  = (tap_state_q == CAP_DR);
        sh_dr   = (tap_state_q == SH_DR);
        upd_dr  = (tap_state_q == UPD_DR);
        ir_side = (tap_state_q == CAP_IR) || (tap_state_q == SH_IR) ||
                  (tap_state_q == EX1_IR) || (tap_state_q == PAU_IR) ||
                  (tap_state_q == EX2_IR) || (tap_state_q == UPD_IR);
    end

    // ---------------------------------------------------------------------
    // IR/DR shift registers, DTM status and DMI request port
    // ---------------------------------------------------------------------
    logic [4:0]  ir_q, ir_d;
    logic [4:0]  ir_shift_q, ir_shift_d;
    logic [40:0] dr_shift_q, dr_shift_d;
    logic        tdo_q, tdo_d;
    logic        tdo_en_q, tdo_en_d;
    logic [1:0]  dmistat_q, dmistat_d;
    logic        busy_q, busy_d;
    logic        discard_q, discard_d;
    logic        resp_pend_q, resp_pend_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic [6:0]  addr_last_q, addr_last_d;
    logic        dmi_valid_q, dmi_valid_d;
    logic        dmi_write_q, dmi_write_d;
    logic [6:0]  dmi_addr_q, dmi_addr_d;
    logic [31:0] dmi_wdata_q, dmi_wdata_d;

    logic [1:0]  dr_sel;
    logic [40:0] dr_shifted;
    logic [31:0] dtmcs_cap;
    logic        busy_eff;
    logic [1:0]  upd_op;

    always_comb begin
        unique case (ir_q)
            IR_IDCODE: dr_sel = SEL_ID;
            IR_DTMCS:  dr_sel = SEL_CS;
            IR_DMI:    dr_sel = SEL_DMI;
            default:   dr_sel = SEL_BYPASS;
        endcase

        // tdi enters at the MSB of whichever register length is selected
        dr_shifted = {1'b0, dr_shift_q[40:1]};
        unique case (dr_sel)
            SEL_DMI:        dr_shifted[40] = tdi_s;
            SEL_ID, SEL_CS: dr_shifted[31] = tdi_s;
            default:        dr_shifted[0]  = tdi_s;
        endcase

        dtmcs_cap = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, dmistat_q, 6'd7, 4'd1};
        // A request finishing on this very clk no longer counts as busy
        busy_eff  = busy_q & ~resp_pend_q;
        upd_op    = dr_shift_q[1:0];
    end

    always_comb begin
        ir_d        = ir_q;
        ir_shift_d  = ir_shift_q;
        dr_shift_d  = dr_shift_q;
        tdo_d       = tdo_q;
        tdo_en_d    = tdo_en_q;
        dmistat_d   = dmistat_q;
        busy_d      = busy_q;
        discard_d   = discard_q;
        resp_pend_d = dmi_valid_q & dmi_ready;
        rdata_buf_d = rdata_buf_q;
        addr_last_d = addr_last_q;
        dmi_valid_d = dmi_valid_q;
        dmi_write_d = dmi_write_q;
        dmi_addr_d  = dmi_addr_q;
        dmi_wdata_d = dmi_wdata_q;

        if (dmi_valid_q && dmi_ready) begin
            dmi_valid_d = 1'b0;
        end
        if (resp_pend_q) begin
            if (!dmi_write_q && !discard_q) begin
                rdata_buf_d = dmi_rdata;
            end
            busy_d    = 1'b0;
            discard_d = 1'b0;
        end

        if (tck_rise) begin
            if (cap_ir) ir_shift_d = 5'b00001;
            if (sh_ir)  ir_shift_d = {tdi_s, ir_shift_q[4:1]};
            if (upd_ir) ir_d = ir_shift_q;

            if (cap_dr) begin
                unique case (dr_sel)
                    SEL_ID: dr_shift_d = {9'b0, IDCODE};
                    SEL_CS: dr_shift_d = {9'b0, dtmcs_cap};
                    SEL_DMI: begin
                        dr_shift_d = {addr_last_q, rdata_buf_q,
                                      busy_eff ? 2'b11 : dmistat_q};
                        if (busy_eff) dmistat_d = 2'b11;
                    end
                    default: dr_shift_d = '0;
                endcase
            end
            if (sh_dr) dr_shift_d = dr_shifted;

            if (upd_dr && dr_sel == SEL_CS) begin
                if (dr_shift_q[16] || dr_shift_q[17]) dmistat_d = 2'b00;
                if (dr_shift_q[17] && busy_eff) discard_d = 1'b1;
            end
            if (upd_dr && dr_sel == SEL_DMI) begin
                if (busy_eff) begin
                    dmistat_d = 2'b11;
                end else if (dmistat_q == 2'b00 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
                    dmi_valid_d = 1'b1;
                    dmi_write_d = (upd_op == 2'd2);
                    dmi_addr_d  = dr_shift_q[40:34];
                    dmi_wdata_d = dr_shift_q[33:2];
                    busy_d      = 1'b1;
                    discard_d   = 1'b0;
                    addr_last_d = dr_shift_q[40:34];
                end
            end
        end

        if (tck_fall) begin
            tdo_d    = ir_side ? ir_shift_q[0] : dr_shift_q[0];
            tdo_en_d = sh_ir | sh_dr;
        end

        // Test-Logic-Reset restores IDCODE but never aborts a DMI handshake
        if (in_tlr) begin
            ir_d      = IR_IDCODE;
            dmistat_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ir_q        <= IR_IDCODE;
            ir_shift_q  <= '0;
            dr_shift_q  <= '0;
            tdo_q       <= 1'b0;
            tdo_en_q    <= 1'b0;
            dmistat_q   <= 2'b00;
            busy_q      <= 1'b0;
            discard_q   <= 1'b0;
            resp_pend_q <= 1'b0;
            rdata_buf_q <= '0;
            addr_last_q <= '0;
            dmi_valid_q <= 1'b0;
            dmi_write_q <= 1'b0;
            dmi_addr_q  <= '0;
            dmi_wdata_q <= '0;
        end else begin
            ir_q        <= ir_d;
            ir_shift_q  <= ir_shift_d;
            dr_shift_q  <= dr_shift_d;
            tdo_q       <= tdo_d;
            tdo_en_q    <= tdo_en_d;
            dmistat_q   <= dmistat_d;
            busy_q      <= busy_d;
            discard_q   <= discard_d;
            resp_pend_q <= resp_pend_d;
            rdata_buf_q <= rdata_buf_d;
            addr_last_q <= addr_last_d;
            dmi_valid_q <= dmi_valid_d;
            dmi_write_q <= dmi_write_d;
            dmi_addr_q  <= dmi_addr_d;
            dmi_wdata_q <= dmi_wdata_d;
        end
    end

    assign tdo       = tdo_q;
    assign tdo_en    = tdo_en_q;
    assign dmi_valid = dmi_valid_q;
    assign dmi_write = dmi_write_q;
    assign dmi_addr  = dmi_addr_q;
    assign dmi_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: bit-bangs the TAP, queues the expected TDO scan
// contents and DMI requests, and independent monitors score what the DUT emits.
module tb_jtag_dtm;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tck = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        dmi_ready = 1'b0;
    logic [31:0] dmi_rdata = 32'h0000_0382;
    logic        tdo, tdo_en, dmi_valid, dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;

    int checks = 0;
    int errors = 0;
    bit auto_ready = 1'b0;

    typedef struct packed {
        logic [7:0]  len;
        logic [63:0] val;
    } scan_t;

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } dmi_t;

    scan_t scan_q[$];
    string scan_nm_q[$];
    dmi_t  dmi_q[$];
    string dmi_nm_q[$];

    jtag_dtm dut (
        .clk       (clk),
        .resetn    (resetn),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .dmi_valid (dmi_valid),
        .dmi_ready (dmi_ready),
        .dmi_write (dmi_write),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Debug module model: one-cycle ready pulse when enabled
    initial forever begin
        @(posedge clk);
        #1;
        dmi_ready = auto_ready && dmi_valid && !dmi_ready;
    end

    // TDO monitor: collects one scan per tdo_en window, LSB first
    initial begin
        logic [63:0] got;
        int          n;
        scan_t       e;
        string       nm;
        got = '0;
        n   = 0;
        forever begin
            @(posedge tck);
            if (tdo_en) begin
                if (n < 64) got[n] = tdo;
                n++;
            end else if (n > 0) begin
                if (scan_q.size() == 0) begin
                    check("unexpected tdo scan length", 64'(n), 64'd0);
                end else begin
                    e  = scan_q.pop_front();
                    nm = scan_nm_q.pop_front();
                    check({nm, " length"}, 64'(n), 64'(e.len));
                    check({nm, " data"}, got, e.val);
                end
                got = '0;
                n   = 0;
            end
        end
    end

    // DMI monitor: request fields on rising valid, stability, drop after handshake
    initial begin
        logic        prev_valid;
        logic        hs;
        logic [39:0] held;
        dmi_t        e;
        string       nm;
        prev_valid = 1'b0;
        hs         = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (hs) check("dmi_valid after handshake", 64'(dmi_valid), 64'd0);
            if (dmi_valid && !prev_valid) begin
                if (dmi_q.size() == 0) begin
                    check("unexpected dmi request addr", 64'(dmi_addr), 64'h7f);
                end else begin
                    e  = dmi_q.pop_front();
                    nm = dmi_nm_q.pop_front();
                    check({nm, " write"}, 64'(dmi_write), 64'(e.wr));
                    check({nm, " addr"},  64'(dmi_addr),  64'(e.addr));
                    check({nm, " wdata"}, 64'(dmi_wdata), 64'(e.wdata));
                end
            end else if (dmi_valid && prev_valid) begin
                check("dmi request held stable", 64'({dmi_write, dmi_addr, dmi_wdata}), 64'(held));
            end
            held       = {dmi_write, dmi_addr, dmi_wdata};
            hs         = dmi_valid && dmi_ready;
            prev_valid = dmi_valid;
        end
    end

    task automatic tck_cycle(input logic m, input logic d);
        tms = m;
        tdi = d;
        #40 tck = 1'b1;
        #40 tck = 1'b0;
    endtask

    task automatic scan_ir(input logic [4:0] ir, input string nm);
        scan_t e;
        e.len = 8'd5;
        e.val = 64'h1;
        scan_q.push_back(e);
        scan_nm_q.push_back(nm);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(i == 4, ir[i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input int len, input logic [63:0] din, input logic [63:0] exp,
                           input string nm);
        scan_t e;
        e.len = 8'(len);
        e.val = exp;
        scan_q.push_back(e);
        scan_nm_q.push_back(nm);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < len; i++) tck_cycle(i == len - 1, din[i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic expect_dmi(input logic wr, input logic [6:0] a, input logic [31:0] d,
                              input string nm);
        dmi_t e;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        dmi_q.push_back(e);
        dmi_nm_q.push_back(nm);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset tdo",       64'(tdo),       64'd0);
        check("reset tdo_en",    64'(tdo_en),    64'd0);
        check("reset dmi_valid", 64'(dmi_valid), 64'd0);
        check("reset dmi_write", 64'(dmi_write), 64'd0);
        check("reset dmi_addr",  64'(dmi_addr),  64'd0);
        check("reset dmi_wdata", 64'(dmi_wdata), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        tck_cycle(1'b0, 1'b0);
        scan_ir(5'h01, "ir idcode");
        scan_dr(32, 64'h0, 64'h1000_0001, "idcode");

        scan_ir(5'h10, "ir dtmcs");
        scan_dr(32, 64'h0, 64'h0000_1071, "dtmcs idle");

        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        scan_dr(32, 64'h0, 64'h1000_0001, "idcode after tlr");

        scan_ir(5'h1F, "ir bypass");
        scan_dr(1, 64'h1, 64'h0, "bypass capture");
        scan_dr(8, 64'hA5, 64'h4A, "bypass delay");

        auto_ready = 1'b1;
        scan_ir(5'h11, "ir dmi");
        expect_dmi(1'b1, 7'h10, 32'h1, "dmi write");
        scan_dr(41, dmi_word(7'h10, 32'h1, 2'd2), 64'h0, "dmi first capture");
        expect_dmi(1'b0, 7'h11, 32'h0, "dmi read");
        scan_dr(41, dmi_word(7'h11, 32'h0, 2'd1), dmi_word(7'h10, 32'h0, 2'd0),
                "dmi after write");
        scan_dr(41, dmi_word(7'h00, 32'h0, 2'd0), dmi_word(7'h11, 32'h382, 2'd0),
                "dmi read data");

        auto_ready = 1'b0;
        expect_dmi(1'b1, 7'h05, 32'hDEAD_BEEF, "dmi stalled write");
        scan_dr(41, dmi_word(7'h05, 32'hDEAD_BEEF, 2'd2), dmi_word(7'h11, 32'h382, 2'd0),
                "dmi before stall");
        scan_dr(41, dmi_word(7'h06, 32'h0, 2'd1), dmi_word(7'h05, 32'h382, 2'd3),
                "dmi busy capture");
        scan_ir(5'h10, "ir dtmcs busy");
        scan_dr(32, 64'h0, 64'h0000_1C71, "dtmcs sticky busy");
        scan_ir(5'h11, "ir dmi ignored");
        scan_dr(41, dmi_word(7'h07, 32'h1234_5678, 2'd2), dmi_word(7'h05, 32'h382, 2'd3),
                "dmi ignored request");
        scan_ir(5'h10, "ir dtmcs clear");
        scan_dr(32, 64'h0001_0000, 64'h0000_1C71, "dtmcs before clear");
        scan_dr(32, 64'h0, 64'h0000_1071, "dtmcs after clear");

        @(negedge clk);
        check("dmi_valid held while stalled", 64'(dmi_valid), 64'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("dmi_valid after reset", 64'(dmi_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        check("scan queue drained", 64'(scan_q.size()), 64'd0);
        check("dmi queue drained",  64'(dmi_q.size()),  64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
